// File: rtl/pool_pkg.sv
// pool_pkg: shared mode/state encodings and output-size helper for the pooling engine
package pool_pkg;
  typedef enum logic [1:0] {POOL_MAX = 2'd0, POOL_MIN = 2'd1, POOL_AVG = 2'd2} pool_mode_e;
  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} pool_state_e;
  function automatic int out_dim(input int row_limit, input int win, input int stride);
    return (row_limit - win) / stride + 1;
  endfunction
endpackage

// File: rtl/pool_window_acc.sv
// pool_window_acc: running max/min/sum over one window, emitting the pooled value with the last element
module pool_window_acc import pool_pkg::*; #(
  parameter int DATA_W = 5,
  parameter int WIN = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] elem,
  input  logic              first,
  input  logic              last,
  output logic [DATA_W-1:0] result,
  output logic              res_valid
);
  localparam int SUM_W = DATA_W + $clog2(WIN * WIN + 1);
  localparam logic [SUM_W-1:0] AREA = SUM_W'(WIN * WIN);
  logic [SUM_W-1:0] acc_q, acc_d, init, base, ext, comb;
  logic is_min, is_avg;
  always_comb begin
    is_min = mode == POOL_MIN;
    is_avg = mode == POOL_AVG;
    init = is_min ? SUM_W'({DATA_W{1'b1}}) : '0;
    base = first ? init : acc_q;
    ext = SUM_W'(elem);
    comb = is_avg ? base + ext : is_min ? (ext < base ? ext : base) : (ext > base ? ext : base);
    acc_d = en ? (last ? init : comb) : acc_q;
    result = DATA_W'(is_avg ? comb / AREA : comb);
    res_valid = en && last;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) acc_q <= '0;
    else acc_q <= acc_d;
  end
endmodule

// File: rtl/pool_engine.sv
// pool_engine: snapshots a square matrix and sweeps a WIN x WIN window at STRIDE into a pooled matrix
module pool_engine import pool_pkg::*; #(
  parameter int DATA_W = 5,
  parameter int ROW_LIMIT = 10,
  parameter int WIN = 3,
  parameter int STRIDE = 1,
  localparam int OUT_DIM = out_dim(ROW_LIMIT, WIN, STRIDE)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [1:0]                          in_mode,
  input  logic [DATA_W*ROW_LIMIT*ROW_LIMIT-1:0] in_matrix,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [DATA_W*OUT_DIM*OUT_DIM-1:0]   out_matrix,
  output logic                                busy
);
  localparam int IN_W = DATA_W * ROW_LIMIT * ROW_LIMIT;
  localparam int OUT_W = DATA_W * OUT_DIM * OUT_DIM;
  localparam int CW = $clog2(ROW_LIMIT + 1);
  localparam int IX_W = $clog2(IN_W);
  localparam int OX_W = $clog2(OUT_W);
  localparam logic [CW-1:0] ONE = 1;
  pool_state_e state_q, state_d;
  logic [IN_W-1:0] snap_q, snap_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic [1:0] mode_q, mode_d;
  logic [CW-1:0] i_q, i_d, j_q, j_d, m_q, m_d, n_q, n_d;
  logic n_wrap, m_wrap, j_wrap, i_wrap, last_elem, sweep_done, accept, computing;
  logic [IX_W-1:0] elem_idx;
  logic [OX_W-1:0] out_idx;
  logic [DATA_W-1:0] elem, acc_res;
  logic acc_valid;
  assign n_wrap = n_q == CW'(WIN - 1);
  assign m_wrap = m_q == CW'(WIN - 1);
  assign j_wrap = j_q == CW'(OUT_DIM - 1);
  assign i_wrap = i_q == CW'(OUT_DIM - 1);
  assign last_elem = n_wrap && m_wrap;
  assign sweep_done = last_elem && j_wrap && i_wrap;
  assign accept = state_q == IDLE && in_valid;
  assign computing = state_q == COMPUTE;
  assign elem_idx = IX_W'(((int'(i_q) * STRIDE + int'(m_q)) * ROW_LIMIT + int'(j_q) * STRIDE + int'(n_q)) * DATA_W);
  assign out_idx = OX_W'((int'(i_q) * OUT_DIM + int'(j_q)) * DATA_W);
  assign elem = snap_q[elem_idx +: DATA_W];
  assign out_matrix = out_q;
  pool_window_acc #(.DATA_W(DATA_W), .WIN(WIN)) u_acc (
    .clk(clk),
    .rst_n(rst_n),
    .en(computing),
    .mode(mode_q),
    .elem(elem),
    .first(n_q == '0 && m_q == '0),
    .last(last_elem),
    .result(acc_res),
    .res_valid(acc_valid)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    if (accept) state_d = COMPUTE;
    if (computing && sweep_done) state_d = DONE;
    if (state_q == DONE && out_ready) state_d = IDLE;
  end
  always_comb begin
    in_ready = state_q == IDLE;
    out_valid = state_q == DONE;
    busy = state_q != IDLE;
  end
  always_comb begin
    snap_d = accept ? in_matrix : snap_q;
    mode_d = accept ? in_mode : mode_q;
    n_d = computing ? (n_wrap ? '0 : n_q + ONE) : state_q == IDLE ? '0 : n_q;
    m_d = computing ? (n_wrap ? (m_wrap ? '0 : m_q + ONE) : m_q) : state_q == IDLE ? '0 : m_q;
    j_d = computing ? (last_elem ? (j_wrap ? '0 : j_q + ONE) : j_q) : state_q == IDLE ? '0 : j_q;
    i_d = computing ? (last_elem && j_wrap ? (i_wrap ? '0 : i_q + ONE) : i_q) : state_q == IDLE ? '0 : i_q;
    out_d = out_q;
    if (acc_valid) out_d[out_idx +: DATA_W] = acc_res;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      snap_q <= '0;
      mode_q <= '0;
      out_q <= '0;
      i_q <= '0;
      j_q <= '0;
      m_q <= '0;
      n_q <= '0;
    end else begin
      snap_q <= snap_d;
      mode_q <= mode_d;
      out_q <= out_d;
      i_q <= i_d;
      j_q <= j_d;
      m_q <= m_d;
      n_q <= n_d;
    end
  end
endmodule

// File: tb/tb_pool_engine.sv
// tb_pool_engine: directed vector table plus handshake, backpressure and reset corner sequences
module tb_pool_engine;
  localparam int IN_W = 500, OUT_W = 320, SIN_W = 216, SOUT_W = 54;
  typedef struct {
    string name;
    logic [1:0] mode;
    logic [IN_W-1:0] mat;
    logic [OUT_W-1:0] exp;
  } vec_t;
  vec_t vecs[6];
  logic clk = 0, rst_n = 0;
  logic in_valid = 0, in_ready, out_valid, out_ready = 0, busy;
  logic [1:0] in_mode = 0;
  logic [IN_W-1:0] in_matrix = '0;
  logic [OUT_W-1:0] out_matrix, saved;
  logic s_in_valid = 0, s_in_ready, s_out_valid, s_out_ready = 0, s_busy;
  logic [1:0] s_in_mode = 0;
  logic [SIN_W-1:0] s_in_matrix = '0;
  logic [SOUT_W-1:0] s_out_matrix, s_exp;
  int n_run = 0, n_fail = 0, cyc;
  logic seen;
  always #5 clk = ~clk;
  pool_engine dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_matrix(in_matrix), .out_valid(out_valid), .out_ready(out_ready), .out_matrix(out_matrix), .busy(busy)
  );
  pool_engine #(.DATA_W(6), .ROW_LIMIT(6), .WIN(2), .STRIDE(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_mode(s_in_mode),
    .in_matrix(s_in_matrix), .out_valid(s_out_valid), .out_ready(s_out_ready), .out_matrix(s_out_matrix), .busy(s_busy)
  );
  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic run_txn(input logic [IN_W-1:0] mat, input logic [1:0] mode, output int c);
    @(negedge clk);
    in_matrix = mat;
    in_mode = mode;
    in_valid = 1;
    chk("accept_ready", in_ready, 1);
    @(posedge clk);
    c = 1;
    @(negedge clk);
    in_valid = 0;
    while (!out_valid && c < 2000) begin
      @(posedge clk);
      c++;
      @(negedge clk);
    end
  endtask
  task automatic end_txn();
    out_ready = 1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 0;
    chk("post_hs_valid", out_valid, 0);
    chk("post_hs_ready", in_ready, 1);
  endtask
  initial begin
    for (int v = 0; v < 6; v++) begin
      vecs[v].mat = '0;
      vecs[v].exp = '0;
    end
    vecs[0].name = "peak_max"; vecs[0].mode = 2'd0;
    vecs[1].name = "ramp_min"; vecs[1].mode = 2'd1;
    vecs[2].name = "avg_floor"; vecs[2].mode = 2'd2;
    vecs[3].name = "ramp_rsvd"; vecs[3].mode = 2'd3;
    vecs[4].name = "ramp_avg"; vecs[4].mode = 2'd2;
    vecs[5].name = "ones_avg"; vecs[5].mode = 2'd2;
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 10; c++) begin
        vecs[0].mat[(r*10+c)*5 +: 5] = (r == 5 && c == 5) ? 5'd31 : 5'd0;
        vecs[1].mat[(r*10+c)*5 +: 5] = 5'(r + c);
        vecs[2].mat[(r*10+c)*5 +: 5] = (r == 0 && c == 0) ? 5'd0 : 5'd9;
        vecs[3].mat[(r*10+c)*5 +: 5] = 5'(r + c);
        vecs[4].mat[(r*10+c)*5 +: 5] = 5'(r + c);
        vecs[5].mat[(r*10+c)*5 +: 5] = 5'd31;
      end
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        vecs[0].exp[(i*8+j)*5 +: 5] = (i >= 3 && i <= 5 && j >= 3 && j <= 5) ? 5'd31 : 5'd0;
        vecs[1].exp[(i*8+j)*5 +: 5] = 5'(i + j);
        vecs[2].exp[(i*8+j)*5 +: 5] = (i == 0 && j == 0) ? 5'd8 : 5'd9;
        vecs[3].exp[(i*8+j)*5 +: 5] = 5'(i + j + 4);
        vecs[4].exp[(i*8+j)*5 +: 5] = 5'(i + j + 2);
        vecs[5].exp[(i*8+j)*5 +: 5] = 5'd31;
      end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_matrix", out_matrix, 0);
    rst_n = 1;
    for (int v = 0; v < 6; v++) begin
      run_txn(vecs[v].mat, vecs[v].mode, cyc);
      chk({vecs[v].name, "_latency"}, cyc, 577);
      chk(vecs[v].name, out_matrix, vecs[v].exp);
      end_txn();
      chk({vecs[v].name, "_retained"}, out_matrix, vecs[v].exp);
    end
    run_txn(vecs[0].mat, vecs[0].mode, cyc);
    chk("bp_result", out_matrix, vecs[0].exp);
    saved = out_matrix;
    in_matrix = vecs[1].mat;
    in_mode = 2'd1;
    in_valid = 1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_hold", out_matrix, saved);
    end
    in_valid = 0;
    end_txn();
    @(posedge clk);
    @(negedge clk);
    chk("bp_no_accept", busy, 0);
    chk("bp_retained", out_matrix, saved);
    @(negedge clk);
    in_matrix = vecs[4].mat;
    in_mode = 2'd2;
    in_valid = 1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    repeat (99) @(posedge clk);
    @(negedge clk);
    chk("mid_busy", busy, 1);
    rst_n = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_matrix", out_matrix, 0);
    chk("mid_rst_busy", busy, 0);
    seen = 0;
    repeat (600) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    chk("mid_rst_no_result", seen, 0);
    run_txn(vecs[1].mat, vecs[1].mode, cyc);
    chk("after_rst_latency", cyc, 577);
    chk("after_rst_result", out_matrix, vecs[1].exp);
    end_txn();
    s_exp = '0;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++) s_in_matrix[(r*6+c)*6 +: 6] = 6'(r * 6 + c);
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) s_exp[(i*3+j)*6 +: 6] = 6'((2*i+1)*6 + 2*j + 1);
    @(negedge clk);
    s_in_mode = 2'd0;
    s_in_valid = 1;
    chk("small_ready", s_in_ready, 1);
    @(posedge clk);
    cyc = 1;
    @(negedge clk);
    s_in_valid = 0;
    while (!s_out_valid && cyc < 200) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    chk("small_latency", cyc, 37);
    chk("small_result", s_out_matrix, s_exp);
    chk("small_out22", s_out_matrix[8*6 +: 6], 35);
    s_out_ready = 1;
    @(posedge clk);
    @(negedge clk);
    s_out_ready = 0;
    chk("small_post_hs_valid", s_out_valid, 0);
    chk("small_post_hs_ready", s_in_ready, 1);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
